// File: rtl/nand_init_seq.sv
// NAND power-up init sequencer: POR settle, wait ready, RESET, wait ready, READ ID.
// All pin and status outputs are registered, decoded from the next state/count.
module nand_init_seq #(
    parameter int unsigned T_POR      = 2500,
    parameter int unsigned T_WP       = 2,
    parameter int unsigned T_WH       = 2,
    parameter int unsigned T_WB       = 8,
    parameter int unsigned T_WHR      = 6,
    parameter int unsigned T_RP       = 2,
    parameter int unsigned T_REH      = 2,
    parameter int unsigned RB_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    output logic       nand_ce_n,
    output logic       nand_cle,
    output logic       nand_ale,
    output logic       nand_we_n,
    output logic       nand_re_n,
    output logic [7:0] nand_dq_o,
    output logic       nand_dq_oe,
    input  logic [7:0] nand_dq_i,
    input  logic       nand_rb_n,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [1:0] err_code,
    output logic [7:0] maker_id,
    output logic [7:0] device_id
);
    typedef enum logic [3:0] {
        S_POR_WAIT, S_RB_WAIT0, S_CMD_RST, S_WB_WAIT, S_RB_WAIT1, S_CMD_ID, S_ADDR,
        S_WHR_WAIT, S_RD0, S_RD1, S_CHECK, S_DONE, S_ERROR
    } state_e;

    localparam logic [15:0] POR_LAST = 16'(T_POR - 1);
    localparam logic [15:0] WP       = 16'(T_WP);
    localparam logic [15:0] WR_LAST  = 16'(T_WP + T_WH - 1);
    localparam logic [15:0] WB_LAST  = 16'(T_WB - 1);
    localparam logic [15:0] WHR_LAST = 16'(T_WHR - 1);
    localparam logic [15:0] RP       = 16'(T_RP);
    localparam logic [15:0] RP_LAST  = 16'(T_RP - 1);
    localparam logic [15:0] RD_LAST  = 16'(T_RP + T_REH - 1);
    localparam logic [15:0] RB_TO    = 16'(RB_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  rb_sync_q, rb_sync_d;
    logic        rb_s;
    logic        ce_n_q, ce_n_d, cle_q, cle_d, ale_q, ale_d;
    logic        we_n_q, we_n_d, re_n_q, re_n_d, dq_oe_q, dq_oe_d;
    logic [7:0]  dq_o_q, dq_o_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  maker_q, maker_d, dev_q, dev_d;

    assign rb_s      = rb_sync_q[1];
    assign rb_sync_d = {rb_sync_q[0], nand_rb_n};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        err_code_d = err_code_q;
        maker_d    = maker_q;
        dev_d      = dev_q;

        case (state_q)
            S_POR_WAIT: if (cnt_q >= POR_LAST) begin state_d = S_RB_WAIT0; cnt_d = '0; end
            S_RB_WAIT0: begin
                // ready wins over a coincident timeout
                if (rb_s) begin
                    state_d = S_CMD_RST; cnt_d = '0;
                end else if (cnt_q >= RB_TO) begin
                    state_d = S_ERROR; cnt_d = '0; err_code_d = 2'd1;
                end
            end
            S_CMD_RST:  if (cnt_q >= WR_LAST) begin state_d = S_WB_WAIT; cnt_d = '0; end
            S_WB_WAIT:  if (cnt_q >= WB_LAST) begin state_d = S_RB_WAIT1; cnt_d = '0; end
            S_RB_WAIT1: begin
                if (rb_s) begin
                    state_d = S_CMD_ID; cnt_d = '0;
                end else if (cnt_q >= RB_TO) begin
                    state_d = S_ERROR; cnt_d = '0; err_code_d = 2'd2;
                end
            end
            S_CMD_ID:   if (cnt_q >= WR_LAST) begin state_d = S_ADDR; cnt_d = '0; end
            S_ADDR:     if (cnt_q >= WR_LAST) begin state_d = S_WHR_WAIT; cnt_d = '0; end
            S_WHR_WAIT: if (cnt_q >= WHR_LAST) begin state_d = S_RD0; cnt_d = '0; end
            S_RD0: begin
                if (cnt_q == RP_LAST) maker_d = nand_dq_i;
                if (cnt_q >= RD_LAST) begin state_d = S_RD1; cnt_d = '0; end
            end
            S_RD1: begin
                if (cnt_q == RP_LAST) dev_d = nand_dq_i;
                if (cnt_q >= RD_LAST) begin state_d = S_CHECK; cnt_d = '0; end
            end
            S_CHECK: begin
                cnt_d = '0;
                if (maker_q == 8'h00 || maker_q == 8'hFF) begin
                    state_d = S_ERROR; err_code_d = 2'd3;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // DONE / ERROR: park until restart
                cnt_d = cnt_q;
                if (restart) begin
                    state_d = S_RB_WAIT0; cnt_d = '0;
                    err_code_d = 2'd0; maker_d = 8'h00; dev_d = 8'h00;
                end
            end
        endcase

        ce_n_d  = 1'b1;
        cle_d   = 1'b0;
        ale_d   = 1'b0;
        we_n_d  = 1'b1;
        re_n_d  = 1'b1;
        dq_o_d  = 8'h00;
        dq_oe_d = 1'b0;
        case (state_d)
            S_RB_WAIT0, S_WB_WAIT, S_RB_WAIT1, S_WHR_WAIT: ce_n_d = 1'b0;
            S_CMD_RST, S_CMD_ID, S_ADDR: begin
                ce_n_d  = 1'b0;
                cle_d   = (state_d != S_ADDR);
                ale_d   = (state_d == S_ADDR);
                dq_o_d  = (state_d == S_CMD_RST) ? 8'hFF : (state_d == S_CMD_ID) ? 8'h90 : 8'h00;
                dq_oe_d = 1'b1;
                we_n_d  = (cnt_d >= WP);
            end
            S_RD0, S_RD1: begin
                ce_n_d = 1'b0;
                re_n_d = (cnt_d >= RP);
            end
            default: ;
        endcase
        busy_d = !(state_d == S_DONE || state_d == S_ERROR);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_POR_WAIT;
            cnt_q      <= '0;
            rb_sync_q  <= '0;
            ce_n_q     <= 1'b1;
            cle_q      <= 1'b0;
            ale_q      <= 1'b0;
            we_n_q     <= 1'b1;
            re_n_q     <= 1'b1;
            dq_o_q     <= 8'h00;
            dq_oe_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            maker_q    <= 8'h00;
            dev_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rb_sync_q  <= rb_sync_d;
            ce_n_q     <= ce_n_d;
            cle_q      <= cle_d;
            ale_q      <= ale_d;
            we_n_q     <= we_n_d;
            re_n_q     <= re_n_d;
            dq_o_q     <= dq_o_d;
            dq_oe_q    <= dq_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            maker_q    <= maker_d;
            dev_q      <= dev_d;
        end
    end

    assign nand_ce_n  = ce_n_q;
    assign nand_cle   = cle_q;
    assign nand_ale   = ale_q;
    assign nand_we_n  = we_n_q;
    assign nand_re_n  = re_n_q;
    assign nand_dq_o  = dq_o_q;
    assign nand_dq_oe = dq_oe_q;
    assign busy       = busy_q;
    assign init_done  = done_q;
    assign init_err   = err_q;
    assign err_code   = err_code_q;
    assign maker_id   = maker_q;
    assign device_id  = dev_q;
endmodule

// File: tb/tb_nand_init_seq.sv
// Bench for nand_init_seq: NAND pin model plus a scoreboard of expected bus writes and results.
module tb_nand_init_seq;
    localparam int T_POR  = 2500;
    localparam int RB_TO  = 1500;

    logic       clk = 1'b0, rst = 1'b1, restart = 1'b0;
    logic       nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n, nand_dq_oe, nand_rb_n;
    logic [7:0] nand_dq_o, nand_dq_i;
    logic       busy, init_done, init_err;
    logic [1:0] err_code;
    logic [7:0] maker_id, device_id;

    nand_init_seq #(.T_POR(T_POR), .RB_TIMEOUT(RB_TO)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .nand_ce_n(nand_ce_n), .nand_cle(nand_cle), .nand_ale(nand_ale),
        .nand_we_n(nand_we_n), .nand_re_n(nand_re_n), .nand_dq_o(nand_dq_o),
        .nand_dq_oe(nand_dq_oe), .nand_dq_i(nand_dq_i), .nand_rb_n(nand_rb_n),
        .busy(busy), .init_done(init_done), .init_err(init_err), .err_code(err_code),
        .maker_id(maker_id), .device_id(device_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_res;
        logic       cle, ale;
        logic [7:0] dq;
        logic       done, err;
        logic [1:0] code;
        logic [7:0] mk, dv;
    } exp_t;
    exp_t q[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, val, lo, hi);
        end
    endtask

    // NAND model: busy after RESET for busy_len cycles, ID bytes on successive reads
    logic [7:0] id0 = 8'h2C, id1 = 8'hDA;
    int  busy_len = 0, rb_cnt = 0, rd_idx = 0;
    bit  rb_stuck = 1'b0;
    assign nand_rb_n = !(rb_stuck || rb_cnt != 0);
    assign nand_dq_i = (rd_idx == 0) ? id0 : id1;

    initial begin
        logic m_we, m_re, m_cle;
        logic [7:0] m_dq;
        m_we = 1'b1; m_re = 1'b1; m_cle = 1'b0; m_dq = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && !m_we && nand_we_n && m_cle && m_dq == 8'hFF) rb_cnt = busy_len;
            else if (rb_cnt > 0) rb_cnt--;
            if (!rst && !m_we && nand_we_n && m_cle && m_dq == 8'h90) rd_idx = 0;
            if (!m_re && nand_re_n) rd_idx++;
            m_we = nand_we_n; m_re = nand_re_n; m_cle = nand_cle; m_dq = nand_dq_o;
        end
    end

    // monitor: pops the scoreboard on each WE rise and on each busy fall
    initial begin
        logic p_we, p_busy, p_cle, p_ale;
        logic [7:0] p_dq;
        exp_t e;
        p_we = 1'b1; p_busy = 1'b1; p_cle = 1'b0; p_ale = 1'b0; p_dq = 8'h00;
        forever begin
            @(negedge clk);
            chk("cle_ale_exclusive", {31'd0, nand_cle & nand_ale}, 32'd0);
            chk("oe_during_read", {31'd0, nand_dq_oe & ~nand_re_n}, 32'd0);
            if (!rst && !p_we && nand_we_n) begin
                if (q.size() == 0) chk("unexpected_write", {24'd0, p_dq}, 32'hFFFF);
                else begin
                    e = q.pop_front();
                    chk("write_kind", {31'd0, e.is_res}, 32'd0);
                    chk("write_byte", {22'd0, p_cle, p_ale, p_dq}, {22'd0, e.cle, e.ale, e.dq});
                end
            end
            if (!rst && p_busy && !busy) begin
                if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("result_kind", {31'd0, e.is_res}, 32'd1);
                    chk("result", {12'd0, init_done, init_err, err_code, maker_id, device_id},
                        {12'd0, e.done, e.err, e.code, e.mk, e.dv});
                end
            end
            p_we = nand_we_n; p_busy = busy; p_cle = nand_cle; p_ale = nand_ale; p_dq = nand_dq_o;
        end
    end

    task automatic push_wr(input logic cle, input logic ale, input logic [7:0] dq);
        exp_t e;
        e = '{is_res: 1'b0, cle: cle, ale: ale, dq: dq, done: 1'b0, err: 1'b0, code: 2'd0, mk: 8'h0, dv: 8'h0};
        q.push_back(e);
    endtask

    task automatic push_res(input logic d, input logic er, input logic [1:0] c, input logic [7:0] mk, input logic [7:0] dv);
        exp_t e;
        e = '{is_res: 1'b1, cle: 1'b0, ale: 1'b0, dq: 8'h0, done: d, err: er, code: c, mk: mk, dv: dv};
        q.push_back(e);
    endtask

    task automatic push_init_writes();
        push_wr(1'b1, 1'b0, 8'hFF);
        push_wr(1'b1, 1'b0, 8'h90);
        push_wr(1'b0, 1'b1, 8'h00);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    // release reset on a negedge and count cycles to the first WE fall
    task automatic por_check(input string nm);
        int n;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < T_POR + 20; i++) begin
            @(negedge clk);
            n++;
            if (!nand_we_n) break;
        end
        chk_rng(nm, n, T_POR + 1, T_POR + 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", {31'd0, nand_ce_n}, 32'd1);
        chk("rst_cle_ale", {30'd0, nand_cle, nand_ale}, 32'd0);
        chk("rst_we_re", {30'd0, nand_we_n, nand_re_n}, 32'd3);
        chk("rst_dq", {23'd0, nand_dq_oe, nand_dq_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_status", {12'd0, init_done, init_err, err_code, maker_id, device_id}, 32'd0);

        // nominal power-up
        push_init_writes();
        push_res(1'b1, 1'b0, 2'd0, 8'h2C, 8'hDA);
        por_check("por_nominal");
        wait_idle("nominal_done", 200);
        chk("done_ce_n", {31'd0, nand_ce_n}, 32'd1);

        // restart from DONE with a slow RESET; restart during RB_WAIT1 is ignored
        id0 = 8'hEC; id1 = 8'hF1; busy_len = 1000;
        push_init_writes();
        push_res(1'b1, 1'b0, 2'd0, 8'hEC, 8'hF1);
        pulse_restart();
        chk("restart_clear", {11'd0, busy, init_done, init_err, err_code, maker_id, device_id}, 32'h0010_0000);
        n = 0;
        while (nand_rb_n && n < 50) begin @(posedge clk); n++; end
        chk("no_por_after_restart", {31'd0, nand_rb_n}, 32'd0);
        saw = 1'b0;
        repeat (500) begin @(negedge clk); if (!nand_we_n) saw = 1'b1; end
        pulse_restart();
        n = 0;
        while (!nand_rb_n && n < 1000) begin @(posedge clk); if (!nand_we_n) saw = 1'b1; n++; end
        chk("no_cmd_while_busy", {31'd0, saw}, 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (!nand_we_n) break;
        end
        chk_rng("cmd_id_latency", n, 2, 4);
        wait_idle("restart_done", 200);
        busy_len = 0;

        // bad maker ID
        id0 = 8'hFF; id1 = 8'hFF;
        push_init_writes();
        push_res(1'b0, 1'b1, 2'd3, 8'hFF, 8'hFF);
        pulse_restart();
        wait_idle("badid_done", 200);

        // R/B# stuck low before RESET
        rb_stuck = 1'b1;
        repeat (5) @(negedge clk);
        push_res(1'b0, 1'b1, 2'd1, 8'h00, 8'h00);
        pulse_restart();
        n = 0;
        while (busy && n < RB_TO + 50) begin @(negedge clk); n++; end
        chk_rng("timeout0_cycles", n, RB_TO, RB_TO + 4);
        chk("timeout0_pins", {30'd0, nand_ce_n, busy}, 32'd2);
        rb_stuck = 1'b0;

        // R/B# stays low after RESET
        busy_len = RB_TO + 100;
        repeat (5) @(negedge clk);
        push_wr(1'b1, 1'b0, 8'hFF);
        push_res(1'b0, 1'b1, 2'd2, 8'h00, 8'h00);
        pulse_restart();
        wait_idle("timeout1_done", RB_TO + 200);
        busy_len = 0;
        n = 0;
        while (!nand_rb_n && n < 300) begin @(negedge clk); n++; end

        // reset during the ADDR write pulse
        id0 = 8'h2C; id1 = 8'hDA;
        push_wr(1'b1, 1'b0, 8'hFF);
        push_wr(1'b1, 1'b0, 8'h90);
        pulse_restart();
        n = 0;
        while (!(nand_ale && !nand_we_n) && n < 100) begin @(negedge clk); n++; end
        chk("reached_addr", {30'd0, nand_ale, nand_we_n}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pins", {28'd0, nand_we_n, nand_ale, nand_ce_n, nand_dq_oe}, 32'hA);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        push_init_writes();
        push_res(1'b1, 1'b0, 2'd0, 8'h2C, 8'hDA);
        por_check("por_after_abort");
        wait_idle("abort_done", 200);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
